// File: rtl/prog_sequencer_pkg.sv
// Shared definitions for the program sequencer: run-state encoding and
// the per-program start address table selected by ProgSel.
package prog_sequencer_pkg;

  typedef enum logic [1:0] {IDLE, LOAD, RUN, HALT} seq_state_t;

  localparam int unsigned START_ADDR [4] = '{0, 128, 256, 384};

endpackage

// File: rtl/pc_next_calc.sv
// Branch resolution: decides whether the current instruction redirects
// the PC and forms the in-page branch address.
module pc_next_calc
  import prog_sequencer_pkg::*;
#(
  parameter int unsigned W = 8,
  parameter int unsigned T = 10
) (
  input  logic [T-1:0] prog_ctr,
  input  logic         branch_ez,
  input  logic         branch_nz,
  input  logic         branch_always,
  input  logic [W-1:0] target,
  input  logic [W-1:0] cond_val,
  output logic [T-1:0] branch_pc,
  output logic         taken
);

  logic cond_zero;

  assign cond_zero = (cond_val == '0);

  // EZ and NZ together are taken whenever either condition holds
  assign taken = branch_always
               | (branch_ez & cond_zero)
               | (branch_nz & ~cond_zero);

  // Targets only reach the low W bits; the page bits are kept
  assign branch_pc = {prog_ctr[T-1:W], target};

endmodule

// File: rtl/prog_sequencer.sv
// Run controller and program counter: start/halt handshake, branch
// resolution, ExecEn gating and a RUN-cycle watchdog.
module prog_sequencer
  import prog_sequencer_pkg::*;
#(
  parameter int unsigned W       = 8,
  parameter int unsigned T       = 10,
  parameter int unsigned MAX_CYC = 4096
) (
  input  logic         Clk,
  input  logic         Reset,
  input  logic         Start,
  input  logic [1:0]   ProgSel,
  input  logic         Done_in,
  input  logic         BranchEZ,
  input  logic         BranchNZ,
  input  logic         BranchAlways,
  input  logic [W-1:0] Target,
  input  logic [W-1:0] CondVal,
  output logic [T-1:0] ProgCtr,
  output logic [T-1:0] ProgCtr_p1,
  output logic         ExecEn,
  output logic         Done,
  output logic         Timeout,
  output logic [15:0]  CycCnt
);

  localparam logic [15:0] WD_LAST = 16'(MAX_CYC - 1);

  seq_state_t   state, state_d;
  logic [1:0]   sel_q, sel_d;
  logic [T-1:0] pc_d;
  logic [15:0]  cyc_d, cyc_inc;
  logic         timeout_d;
  logic [T-1:0] branch_pc;
  logic         taken;

  pc_next_calc #(.W(W), .T(T)) u_pc_next_calc (
    .prog_ctr      (ProgCtr),
    .branch_ez     (BranchEZ),
    .branch_nz     (BranchNZ),
    .branch_always (BranchAlways),
    .target        (Target),
    .cond_val      (CondVal),
    .branch_pc     (branch_pc),
    .taken         (taken)
  );

  assign ProgCtr_p1 = ProgCtr + T'(1);
  assign ExecEn     = (state == RUN);
  assign Done       = (state == HALT);
  assign cyc_inc    = (CycCnt == 16'hFFFF) ? CycCnt : CycCnt + 16'd1;

  always_comb begin
    state_d   = state;
    sel_d     = sel_q;
    pc_d      = ProgCtr;
    cyc_d     = CycCnt;
    timeout_d = Timeout;
    case (state)
      IDLE, HALT: begin
        if (Start) begin
          state_d = LOAD;
          sel_d   = ProgSel;
        end
      end
      LOAD: begin
        pc_d      = T'(START_ADDR[sel_q]);
        cyc_d     = '0;
        timeout_d = 1'b0;
        state_d   = RUN;
      end
      RUN: begin
        cyc_d = cyc_inc;
        // DNE outranks the watchdog; both leave the PC on the last instruction
        if (Done_in) begin
          state_d   = HALT;
          timeout_d = 1'b0;
        end else if (CycCnt == WD_LAST) begin
          state_d   = HALT;
          timeout_d = 1'b1;
        end else begin
          pc_d = taken ? branch_pc : ProgCtr_p1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state   <= IDLE;
      sel_q   <= '0;
      ProgCtr <= '0;
      CycCnt  <= '0;
      Timeout <= 1'b0;
    end else begin
      state   <= state_d;
      sel_q   <= sel_d;
      ProgCtr <= pc_d;
      CycCnt  <= cyc_d;
      Timeout <= timeout_d;
    end
  end

endmodule
